// File: rtl/zombie_spawner.sv
// Zombie placement engine: LFSR-driven hole choice, exposure/gap timing, hit and miss tallies.
// Optional build macro ZOMBIE_NO_REPEAT_EN rotates a hole that repeats the previous round's hole.
module zombie_spawner #(
  parameter int unsigned SHOW_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               need_random,
  input  logic               shift,
  input  logic               stop,
  output logic               MD1,
  output logic               MD2,
  output logic               MD3,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss,
  output logic               busy
);

  // state | meaning
  // IDLE  | no round running, holes empty, waiting for need_random
  // SPAWN | one cycle: pick the hole from the LFSR, clear the timer
  // SHOW  | zombie up; a hit or the exposure timeout ends it
  // GAP   | holes empty for GAP_CYCLES before the next spawn

  localparam int unsigned MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [7:0]    SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [SCORE_W-1:0] SAT  = '1;

  typedef enum logic [1:0] {IDLE, SPAWN, SHOW, GAP} state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [TW-1:0] timer;
  logic [2:0]    md;
  logic [1:0]    pick;
  logic [2:0]    pick_oh;
`ifdef ZOMBIE_NO_REPEAT_EN
  logic [1:0]    prev_hole;  // 0 = none, else hole 1..3
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_comb begin
    pick = 2'd1;
    case (lfsr[1:0])
      2'd1:    pick = 2'd2;
      2'd2:    pick = 2'd3;
      default: pick = 2'd1;
    endcase
`ifdef ZOMBIE_NO_REPEAT_EN
    if (pick == prev_hole) pick = (pick == 2'd3) ? 2'd1 : pick + 2'd1;
`endif
  end

  always_comb begin
    pick_oh = 3'b000;
    case (pick)
      2'd1:    pick_oh = 3'b001;
      2'd2:    pick_oh = 3'b010;
      2'd3:    pick_oh = 3'b100;
      default: pick_oh = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      md    <= '0;
      score <= '0;
      miss  <= '0;
`ifdef ZOMBIE_NO_REPEAT_EN
      prev_hole <= 2'd0;
`endif
    end else if (stop) begin
      // abort keeps the tallies so the display still shows the last game
      state <= IDLE;
      timer <= '0;
      md    <= '0;
`ifdef ZOMBIE_NO_REPEAT_EN
      prev_hole <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (need_random) begin
            state <= SPAWN;
            timer <= '0;
            score <= '0;
            miss  <= '0;
          end
        end
        SPAWN: begin
          state <= SHOW;
          timer <= '0;
          md    <= pick_oh;
`ifdef ZOMBIE_NO_REPEAT_EN
          prev_hole <= pick;
`endif
        end
        SHOW: begin
          // a hit on the timeout cycle still counts as a hit
          if (shift) begin
            score <= (score == SAT) ? score : score + 1'b1;
            md    <= '0;
            timer <= '0;
            state <= GAP;
          end else if (timer == SHOW_LAST) begin
            miss  <= (miss == SAT) ? miss : miss + 1'b1;
            md    <= '0;
            timer <= '0;
            state <= GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            state <= SPAWN;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          md    <= '0;
        end
      endcase
    end
  end

  assign MD1  = md[0];
  assign MD2  = md[1];
  assign MD3  = md[2];
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_zombie_spawner.sv
// Scoreboard bench for zombie_spawner: driver queues per-round expectations, monitor checks on MD edges.
// Honours ZOMBIE_NO_REPEAT_EN when the design is built with it.
module tb_zombie_spawner;
  localparam int SHOW = 4;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic need_random = 1'b0;
  logic shift = 1'b0;
  logic stop = 1'b0;

  logic       md1, md2, md3, busy;
  logic [7:0] score, miss;
  logic       b_md1, b_md2, b_md3, b_busy;
  logic [1:0] b_score, b_miss;

  always #5 clk = ~clk;

  zombie_spawner #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .LFSR_SEED(8'hA5), .SCORE_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .need_random(need_random), .shift(shift), .stop(stop),
    .MD1(md1), .MD2(md2), .MD3(md3), .score(score), .miss(miss), .busy(busy));

  zombie_spawner #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .LFSR_SEED(8'hA5), .SCORE_W(2)) u_dut_narrow (
    .clk(clk), .rst_n(rst_n), .need_random(need_random), .shift(shift), .stop(stop),
    .MD1(b_md1), .MD2(b_md2), .MD3(b_md3), .score(b_score), .miss(b_miss), .busy(b_busy));

  int total = 0;
  int bad = 0;

  typedef struct {
    int dur;
    int sc;
    int mi;
  } exp_t;
  exp_t exp_q[$];
  int exp_score = 0;
  int exp_miss = 0;

  logic [2:0] prev_md = 3'b000;
  int  high_cnt = 0;
  int  low_cnt = 0;
  bit  gap_valid = 1'b0;
  int  last_hole = 0;
  int  model_prev = 0;
  int  cov[4] = '{0, 0, 0, 0};

  logic [7:0] m_lfsr, m_prev_lfsr;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // reference LFSR, one step per edge out of reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr      <= 8'hA5;
      m_prev_lfsr <= 8'hA5;
    end else begin
      m_prev_lfsr <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // monitor
  initial begin
    forever begin
      logic [2:0] md;
      int act_hole, eh;
      exp_t e;
      @(negedge clk);
      md = {md3, md2, md1};
      if (!rst_n) begin
        prev_md   = 3'b000;
        gap_valid = 1'b0;
        last_hole = 0;
        model_prev = 0;
      end else begin
        check("md_onehot0", int'($onehot0(md)), 1);
        if (md != 3'b000 && prev_md == 3'b000) begin
          act_hole = (md == 3'b001) ? 1 : (md == 3'b010) ? 2 : (md == 3'b100) ? 3 : 0;
          case (m_prev_lfsr[1:0])
            2'd1:    eh = 2;
            2'd2:    eh = 3;
            default: eh = 1;
          endcase
`ifdef ZOMBIE_NO_REPEAT_EN
          if (eh == model_prev) eh = (eh == 3) ? 1 : eh + 1;
          if (last_hole != 0) check("no_repeat", int'(act_hole != last_hole), 1);
`endif
          model_prev = eh;
          check("hole", act_hole, eh);
          last_hole = act_hole;
          if (act_hole > 0) cov[act_hole]++;
          if (gap_valid) check("gap_len", low_cnt, GAP + 1);
          high_cnt = 1;
        end else if (md != 3'b000) begin
          high_cnt++;
        end else if (prev_md != 3'b000) begin
          if (exp_q.size() == 0) begin
            check("unexpected_round_end", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("md_high_len", high_cnt, e.dur);
            check("score", int'(score), sat(e.sc, 255));
            check("miss", int'(miss), sat(e.mi, 255));
            check("score_w2", int'(b_score), sat(e.sc, 3));
            check("miss_w2", int'(b_miss), sat(e.mi, 3));
          end
          low_cnt = 1;
          gap_valid = 1'b1;
        end else begin
          low_cnt++;
        end
        prev_md = md;
      end
    end
  end

  task automatic wait_md(input bit want_high, input string name);
    int t = 0;
    while (((md1 | md2 | md3) != want_high) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) check(name, 0, 1);
  endtask

  task automatic run_round(input int hit_at);
    exp_t e;
    if (hit_at > 0) begin
      exp_score++;
      e.dur = hit_at;
    end else begin
      exp_miss++;
      e.dur = SHOW;
    end
    e.sc = exp_score;
    e.mi = exp_miss;
    exp_q.push_back(e);
    wait_md(1'b1, "timeout_rise");
    if (hit_at > 0) begin
      repeat (hit_at - 1) @(negedge clk);
      shift = 1'b1;
      @(negedge clk);
      shift = 1'b0;
    end
    wait_md(1'b0, "timeout_fall");
  endtask

  task automatic start_round();
    need_random = 1'b1;
    @(negedge clk);
    need_random = 1'b0;
    exp_score  = 0;
    exp_miss   = 0;
    gap_valid  = 1'b0;
    last_hole  = 0;
    model_prev = 0;
    check("start_busy", int'(busy), 1);
    check("start_md", int'({md3, md2, md1}), 0);
    check("start_score_clr", int'(score), 0);
    check("start_miss_clr", int'(miss), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_md", int'({md3, md2, md1}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_score", int'(score), 0);
    check("rst_miss", int'(miss), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    start_round();
    run_round(0);
    run_round(2);
    run_round(SHOW);
    run_round(1);
    run_round(3);
    run_round(1);

    // stop in the first GAP cycle
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_md", int'({md3, md2, md1}), 0);
    check("stop_score_held", int'(score), 5);
    check("stop_miss_held", int'(miss), 1);
    repeat (4) @(negedge clk);
    check("idle_stays_empty", int'({md3, md2, md1, busy}), 0);

    start_round();
    run_round(2);

    // asynchronous reset in the middle of SHOW
    wait_md(1'b1, "timeout_rise_rst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_md", int'({md3, md2, md1}), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_score", int'(score), 0);
    check("arst_miss", int'(miss), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    start_round();
    for (int r = 0; r < 300; r++) run_round(r % 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("final_busy", int'(busy), 0);
    check("cov_hole1", int'(cov[1] > 0), 1);
    check("cov_hole2", int'(cov[2] > 0), 1);
    check("cov_hole3", int'(cov[3] > 0), 1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
